// File: rtl/employee_rec_deser_if.sv
// Byte-stream in / record out handshake bundle for the employee record deserialiser.
// The master side feeds bytes and consumes records; the slave side is the deserialiser.
interface employee_rec_deser_if #(
  parameter int AGE_W = 32,
  parameter int ID_W  = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_sof;
  logic             rec_valid;
  logic             rec_ready;
  logic [AGE_W-1:0] rec_age;
  logic [ID_W-1:0]  rec_id;

  modport master (
    output in_valid, in_data, in_sof, rec_ready,
    input  in_ready, rec_valid, rec_age, rec_id
  );

  modport slave (
    input  in_valid, in_data, in_sof, rec_ready,
    output in_ready, rec_valid, rec_age, rec_id
  );
endinterface

// File: rtl/employee_rec_deser.sv
// Reassembles a packed {age, id} employee record from an MSB-first framed byte
// stream and holds it on a valid/ready port until the consumer takes it.
// Framing errors (stray bytes in IDLE, restarts mid-frame) bump a saturating counter.
module employee_rec_deser #(
  parameter int AGE_W     = 32,
  parameter int ID_W      = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  employee_rec_deser_if.slave  bus,
  output logic [4:0]           state_o,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int REC_W     = AGE_W + ID_W;
  localparam int REC_BYTES = REC_W / 8;
  localparam int CNT_W     = $clog2(REC_BYTES + 1);

  typedef enum logic [4:0] {
    IDLE  = 5'd2,
    COUNT = 5'd7,
    LAST  = 5'd11
  } fsm_e;

  fsm_e                 state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  // Only the first REC_BYTES-1 bytes ever need storing; the final byte is
  // merged straight into the latched record.
  logic [REC_W-9:0]     shift_reg;
  logic                 rec_valid_reg;
  logic [AGE_W-1:0]     rec_age_reg;
  logic [ID_W-1:0]      rec_id_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;

  logic                 accept;
  logic                 err_sat;
  logic [REC_W-1:0]     word_next;

  // Ready is a pure function of state (and reset), never of in_valid.
  assign bus.in_ready  = !reset && (state_reg == IDLE || state_reg == COUNT);
  assign accept        = bus.in_valid && bus.in_ready;
  assign err_sat       = &err_cnt_reg;
  assign word_next     = {shift_reg, bus.in_data};

  assign bus.rec_valid = rec_valid_reg;
  assign bus.rec_age   = rec_age_reg;
  assign bus.rec_id    = rec_id_reg;
  assign state_o       = state_reg;
  assign err_cnt       = err_cnt_reg;

  // Framing FSM: byte collection, record latch, output handshake and error count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      rec_valid_reg <= 1'b0;
      rec_age_reg   <= '0;
      rec_id_reg    <= '0;
      err_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (bus.in_sof) begin
              shift_reg <= (REC_W-8)'(bus.in_data);
              cnt_reg   <= CNT_W'(1);
              state_reg <= COUNT;
            end else if (!err_sat) begin
              err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
            end
          end
        end
        COUNT: begin
          if (accept) begin
            if (bus.in_sof) begin
              // Restart: the partial frame is dropped and this byte opens a new one.
              if (!err_sat) begin
                err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
              end
              shift_reg <= (REC_W-8)'(bus.in_data);
              cnt_reg   <= CNT_W'(1);
            end else if (cnt_reg == CNT_W'(REC_BYTES - 1)) begin
              rec_age_reg   <= word_next[REC_W-1:ID_W];
              rec_id_reg    <= word_next[ID_W-1:0];
              rec_valid_reg <= 1'b1;
              cnt_reg       <= '0;
              state_reg     <= LAST;
            end else begin
              shift_reg <= word_next[REC_W-9:0];
              cnt_reg   <= cnt_reg + CNT_W'(1);
            end
          end
        end
        LAST: begin
          if (bus.rec_ready) begin
            rec_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          rec_valid_reg <= 1'b0;
          cnt_reg       <= '0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_employee_rec_deser.sv
// Randomised scoreboard bench for employee_rec_deser: stimulus feeds a
// frame-level model that queues expected records; a monitor checks every
// presented record against the queue head.
module tb_employee_rec_deser;
  logic       clk;
  logic       reset;
  logic [4:0] state_o;
  logic [7:0] err_cnt;

  employee_rec_deser_if #(.AGE_W(32), .ID_W(16)) bus ();

  employee_rec_deser #(.AGE_W(32), .ID_W(16), .ERR_CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o),
    .err_cnt (err_cnt)
  );

  typedef struct {
    logic [31:0] age;
    logic [15:0] id;
    int          err;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] frame_q[$];
  int         model_err;
  int         checks;
  int         failures;
  int         rdy_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_err_inc();
    if (model_err < 255) model_err++;
  endtask

  // Frame-level reference: a record is six accepted bytes starting with sof.
  task automatic model_accept(input logic [7:0] b, input logic sof);
    longint unsigned word;
    rec_t r;
    if (sof) begin
      if (frame_q.size() > 0) model_err_inc();
      frame_q.delete();
      frame_q.push_back(b);
    end else if (frame_q.size() == 0) begin
      model_err_inc();
    end else begin
      frame_q.push_back(b);
    end
    if (frame_q.size() == 6) begin
      word = 0;
      foreach (frame_q[i]) word = word * 256 + longint'(frame_q[i]);
      r.age = 32'(word / 65536);
      r.id  = 16'(word % 65536);
      r.err = model_err;
      exp_q.push_back(r);
      frame_q.delete();
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [7:0] b, input logic sof, input int gap);
    int guard;
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_sof   = sof;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(b, sof);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame6(input logic [47:0] w, input int gmax);
    logic [47:0] t;
    t = w;
    for (int i = 0; i < 6; i++) begin
      send(t[47:40], (i == 0), $urandom_range(0, gmax));
      t = t << 8;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_state", 64'(state_o), 64'd2);
    chk("rst_rec_valid", 64'(bus.rec_valid), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_rec_age", 64'(bus.rec_age), 64'd0);
    exp_q.delete();
    frame_q.delete();
    model_err = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  // Consumer ready, changed shortly after each rising edge.
  initial begin
    bus.rec_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: bus.rec_ready = 1'b1;
        1: bus.rec_ready = 1'($urandom_range(0, 1));
        default: bus.rec_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every presented record must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && bus.rec_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rec: got age=%0h id=%0h expected no record", bus.rec_age, bus.rec_id);
      end else begin
        chk("mon_age", 64'(bus.rec_age), 64'(exp_q[0].age));
        chk("mon_id", 64'(bus.rec_id), 64'(exp_q[0].id));
        chk("mon_err", 64'(err_cnt), 64'(exp_q[0].err));
        chk("mon_state", 64'(state_o), 64'd11);
        chk("mon_in_ready", 64'(bus.in_ready), 64'd0);
        if (bus.rec_ready) begin
          $display("rec age=%08h id=%04h err=%0d", bus.rec_age, bus.rec_id, err_cnt);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int guard;
    int kind;
    int n;
    checks = 0;
    failures = 0;
    model_err = 0;
    rdy_mode = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_sof = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single record, continuous stream, consumer ready.
    send_frame6(48'hDEAD_BEAF_254C, 0);
    chk("single_valid", 64'(bus.rec_valid), 64'd1);
    chk("single_state", 64'(state_o), 64'd11);
    chk("single_age", 64'(bus.rec_age), 64'hDEADBEAF);
    chk("single_id", 64'(bus.rec_id), 64'd9548);
    @(negedge clk);
    chk("single_back_idle", 64'(state_o), 64'd2);

    // Backpressure with input gaps.
    rdy_mode = 2;
    @(negedge clk);
    send_frame6(48'h0000_0021_254C, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(bus.rec_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_age", 64'(bus.rec_age), 64'd33);
      chk("bp_id", 64'(bus.rec_id), 64'd9548);
      @(negedge clk);
    end
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_back_idle", 64'(state_o), 64'd2);

    // Mid-simulation reset, then resync after a truncated frame.
    do_reset();
    send(8'h11, 1'b1, 0);
    send(8'h22, 1'b0, 0);
    send(8'h33, 1'b0, 0);
    send_frame6(48'h1234_5678_ABCD, 0);
    chk("resync_age", 64'(bus.rec_age), 64'h12345678);
    chk("resync_id", 64'(bus.rec_id), 64'hABCD);
    chk("resync_err", 64'(err_cnt), 64'd1);
    @(negedge clk);

    // Stray bytes in IDLE, then saturation.
    do_reset();
    send(8'h5A, 1'b0, 0);
    send(8'hA5, 1'b0, 0);
    chk("stray_err2", 64'(err_cnt), 64'd2);
    chk("stray_state", 64'(state_o), 64'd2);
    chk("stray_no_valid", 64'(bus.rec_valid), 64'd0);
    for (int i = 0; i < 298; i++) send(8'($urandom), 1'b0, 0);
    chk("stray_sat", 64'(err_cnt), 64'd255);
    chk("stray_sat_model", 64'(err_cnt), 64'(model_err));

    // Reset mid-frame discards the partial frame.
    do_reset();
    send(8'hDE, 1'b1, 0);
    send(8'hAD, 1'b0, 0);
    send(8'hBE, 1'b0, 0);
    send(8'hAF, 1'b0, 0);
    do_reset();
    repeat (3) @(negedge clk);
    chk("midrst_no_valid", 64'(bus.rec_valid), 64'd0);
    send_frame6(48'hDEAD_BEAF_254C, 0);
    chk("midrst_age", 64'(bus.rec_age), 64'hDEADBEAF);
    chk("midrst_id", 64'(bus.rec_id), 64'd9548);
    chk("midrst_err", 64'(err_cnt), 64'd0);
    @(negedge clk);

    // Random mix of full frames, truncated frames and stray bytes.
    do_reset();
    rdy_mode = 1;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        send_frame6({16'($urandom), 32'($urandom)}, 2);
      end else if (kind < 8) begin
        n = $urandom_range(1, 5);
        for (int j = 0; j < n; j++) send(8'($urandom), (j == 0), $urandom_range(0, 2));
      end else begin
        send(8'($urandom), 1'b0, $urandom_range(0, 2));
      end
    end

    // Drain the scoreboard.
    rdy_mode = 0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("final_err", 64'(err_cnt), 64'(model_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
